// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the single-cycle RISC-V core.
// Holds the fetch address and chooses the next PC from four sources:
// sequential step, branch/jump redirect, trap entry and trap return.
// Also flags misaligned redirects, captures the EPC on trap entry and
// counts retired instructions.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   stall            hold the PC this cycle
//   redirect_valid   branch/jump taken; redirect_target is the new PC
//   trap_req         enter the trap handler at TRAP_VEC
//   trap_ret         return from trap to epc
//   address          current fetch PC (registered)
//   pc_plus_step     address + STEP (combinational, wraps)
//   pc_valid         address is a valid fetch this cycle
//   misaligned       one-cycle pulse after a misaligned redirect was trapped
//   epc              PC saved at the last trap entry (registered)
//   instret          retired-instruction count (registered, wraps)
module pc_unit #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_VEC = XLEN'(32'h0),
    parameter logic [XLEN-1:0]   TRAP_VEC  = XLEN'(32'h100),
    parameter int unsigned       ALIGN     = 2,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              trap_req,
    input  logic              trap_ret,
    output logic [XLEN-1:0]   address,
    output logic [XLEN-1:0]   pc_plus_step,
    output logic              pc_valid,
    output logic              misaligned,
    output logic [XLEN-1:0]   epc,
    output logic [CNT_W-1:0]  instret
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(1) << ALIGN;
    // Low address bits that must be zero; all-zero mask when ALIGN == 0.
    localparam logic [XLEN-1:0] ALIGN_MASK = STEP - XLEN'(1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t state;
    logic   target_misaligned;

    assign target_misaligned = |(redirect_target & ALIGN_MASK);
    assign pc_plus_step      = address + STEP;
    assign pc_valid          = (state == RUN);

    // Next-PC selection FSM; BOOT and TRAP are single bubble cycles that ignore inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            address    <= RESET_VEC;
            epc        <= '0;
            instret    <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            unique case (state)
                BOOT: state <= RUN;
                TRAP: state <= RUN;
                RUN: begin
                    if (trap_req) begin
                        epc     <= address;
                        address <= TRAP_VEC;
                        state   <= TRAP;
                    end else if (redirect_valid && target_misaligned) begin
                        misaligned <= 1'b1;
                        epc        <= address;
                        address    <= TRAP_VEC;
                        state      <= TRAP;
                    end else if (redirect_valid) begin
                        // Redirect takes precedence over stall.
                        address <= redirect_target;
                        instret <= instret + CNT_W'(1);
                    end else if (trap_ret) begin
                        address <= epc;
                        instret <= instret + CNT_W'(1);
                    end else if (!stall) begin
                        address <= pc_plus_step;
                        instret <= instret + CNT_W'(1);
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a reference model pushes expected state to
// a scoreboard queue as each cycle's stimulus is driven; the entry is popped
// and compared after the edge. A second 8-bit instance covers address wrap.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, trap_req, trap_ret;
    logic [31:0] redirect_target;
    logic [31:0] address, pc_plus_step, epc, instret;
    logic        pc_valid, misaligned;

    logic        reset8;
    logic        zero8_bit;
    logic [7:0]  zero8_vec;
    logic [7:0]  address8, pc_plus_step8, epc8;
    logic [31:0] instret8;
    logic        pc_valid8, misaligned8;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic        mis;
        logic [31:0] epc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    int          m_state;   // 0 BOOT, 1 RUN, 2 TRAP
    logic [31:0] m_addr, m_epc, m_cnt;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_req(trap_req), .trap_ret(trap_ret),
        .address(address), .pc_plus_step(pc_plus_step), .pc_valid(pc_valid),
        .misaligned(misaligned), .epc(epc), .instret(instret)
    );

    pc_unit #(.XLEN(8), .RESET_VEC(8'hF8), .TRAP_VEC(8'h80)) dut8 (
        .clk(clk), .reset(reset8), .stall(zero8_bit),
        .redirect_valid(zero8_bit), .redirect_target(zero8_vec),
        .trap_req(zero8_bit), .trap_ret(zero8_bit),
        .address(address8), .pc_plus_step(pc_plus_step8), .pc_valid(pc_valid8),
        .misaligned(misaligned8), .epc(epc8), .instret(instret8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge for the given inputs.
    task automatic model(input logic rst, input logic st, input logic rv,
                         input logic [31:0] tgt, input logic tr, input logic ret);
        if (rst) begin
            m_state = 0; m_addr = 32'h0; m_epc = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (m_state != 1) begin
                m_state = 1;
            end else if (tr) begin
                m_epc = m_addr; m_addr = 32'h100; m_state = 2;
            end else if (rv && tgt[1:0] != 2'b00) begin
                m_mis = 1'b1; m_epc = m_addr; m_addr = 32'h100; m_state = 2;
            end else if (rv) begin
                m_addr = tgt; m_cnt = m_cnt + 1;
            end else if (ret) begin
                m_addr = m_epc; m_cnt = m_cnt + 1;
            end else if (!st) begin
                m_addr = m_addr + 4; m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic st, input logic rv,
                       input logic [31:0] tgt, input logic tr, input logic ret);
        exp_t e;
        reset = rst; stall = st; redirect_valid = rv;
        redirect_target = tgt; trap_req = tr; trap_ret = ret;
        model(rst, st, rv, tgt, tr, ret);
        e.addr = m_addr; e.valid = (m_state == 1); e.mis = m_mis;
        e.epc = m_epc; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("address", address, e.addr);
        chk("pc_valid", 32'(pc_valid), 32'(e.valid));
        chk("misaligned", 32'(misaligned), 32'(e.mis));
        chk("epc", epc, e.epc);
        chk("instret", instret, e.cnt);
        chk("pc_plus_step", pc_plus_step, e.addr + 32'd4);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] r_tgt;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_req = 1'b0; trap_ret = 1'b0;
        reset8 = 1'b1; zero8_bit = 1'b0; zero8_vec = 8'h00;
        m_state = 0; m_addr = 0; m_epc = 0; m_cnt = 0; m_mis = 0;
        #1;

        // T1: reset, boot bubble, sequential fetch.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t1_boot_addr", address, 32'h0);
        chk("t1_boot_valid", 32'(pc_valid), 32'h0);
        repeat (4) idle();
        chk("t1_addr_c", address, 32'hC);
        chk("t1_instret_3", instret, 32'd3);

        // T2: stall holds PC and counter; redirect overrides stall.
        cyc(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t2_stall_addr", address, 32'h8);
        chk("t2_stall_cnt", instret, 32'd4);
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        chk("t2_redirect_over_stall", address, 32'h40);

        // T3: trap entry, bubble, resume, mret.
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t3_trap_addr", address, 32'h100);
        chk("t3_trap_epc", epc, 32'h10);
        chk("t3_trap_bubble", 32'(pc_valid), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);   // second trap_req ignored in TRAP
        idle();
        chk("t3_after_trap", address, 32'h104);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_mret", address, 32'h10);

        // T4: misaligned redirect traps without counting.
        cyc(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
        chk("t4_mis_pulse", 32'(misaligned), 32'h1);
        chk("t4_mis_epc", epc, 32'h20);
        chk("t4_mis_addr", address, 32'h100);
        chk("t4_mis_cnt", instret, 32'd9);
        idle();
        chk("t4_mis_clear", 32'(misaligned), 32'h0);

        // T5: trap beats redirect; reset during TRAP.
        idle();
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
        chk("t5_trap_wins", address, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t5_reset_in_trap", address, 32'h0);
        chk("t5_reset_epc", epc, 32'h0);

        // Random mix against the model.
        repeat (2) idle();
        for (int i = 0; i < 60; i++) begin
            r_tgt = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(0, 7) == 0);
            cyc(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), r_tgt,
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // T6: 8-bit instance wraps from FC to 00.
        reset8 = 1'b1;
        @(posedge clk); #1;
        chk("t6_reset_addr", 32'(address8), 32'hF8);
        chk("t6_boot_valid", 32'(pc_valid8), 32'h0);
        reset8 = 1'b0;
        @(posedge clk); #1;
        chk("t6_run_f8", 32'(address8), 32'hF8);
        chk("t6_run_valid", 32'(pc_valid8), 32'h1);
        @(posedge clk); #1;
        chk("t6_fc", 32'(address8), 32'hFC);
        chk("t6_step_wrap", 32'(pc_plus_step8), 32'h00);
        @(posedge clk); #1;
        chk("t6_wrap_00", 32'(address8), 32'h00);
        chk("t6_instret", instret8, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
